trng_ps_bridge: RTL and testbench
=================================

TRNG_PS_BRIDGE -- requirements
Module: trng_ps_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning word width in bits; legal values 8..64.
REQ-002 SHALL have parameter DEPTH, default 1024, meaning FIFO depth in words; power of 2, at least 4.
REQ-003 SHALL have parameter RCT_CUTOFF, default 32, meaning the repetition-count health-test limit in raw bits; legal values 2..255.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 SHALL have port clk, input, 1 bit, the single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_btn_n, input, 1 bit, synchronous active-low reset.
REQ-007 SHALL have port enable, input, 1 bit, entropy collection on.
REQ-008 SHALL have port vn_enable, input, 1 bit, Von Neumann correction on.
REQ-009 SHALL have port raw_bit, input, 1 bit, sampled oscillator bit.
REQ-010 SHALL have port raw_valid, input, 1 bit, raw_bit qualifier.
REQ-011 SHALL have port ps_rd_en, input, 1 bit, PS pops the head word.
REQ-012 SHALL have port irq_thresh, input, LW = clog2(DEPTH)+1 bits, ready threshold.
REQ-013 SHALL have port clear_status, input, 1 bit, clears the sticky flags.
REQ-014 SHALL have port ps_rd_data, output, DATA_W bits, FIFO head word.
REQ-015 SHALL have port fifo_empty, output, 1 bit, no word available.
REQ-016 SHALL have port fifo_level, output, LW bits, words stored.
REQ-017 SHALL have port data_ready, output, 1 bit, asserted when level is at or above the threshold.
REQ-018 SHALL have port overflow, output, 1 bit, sticky: a word was dropped.
REQ-019 SHALL have port health_fail, output, 1 bit, sticky: the repetition-count test tripped.

Function
REQ-020 SHALL accept a raw bit only in a cycle where enable=1, raw_valid=1 and health_fail=0.
REQ-021 SHALL, with vn_enable=0, pass every accepted raw bit to the packer.
REQ-022 SHALL, with vn_enable=1, pair consecutive accepted bits: pair 01 emits 0, pair 10 emits 1, pairs 00 and 11 emit nothing.
REQ-023 SHALL clear the Von Neumann pair state whenever vn_enable changes or enable=0; the partial word is kept on a vn_enable change only.
REQ-024 SHALL pack emitted bits MSB first: the first bit lands in bit DATA_W-1, and a bit counter counts 0..DATA_W-1.
REQ-025 SHALL issue a FIFO write exactly one cycle after the DATA_W-th bit, with the counter wrapping to 0 at the same time.
REQ-026 SHALL, when enable=0, hold the bit counter at 0 and discard any partial word; FIFO contents are retained and stay readable.
REQ-027 SHALL make the FIFO first-word-fall-through: ps_rd_data shows the head word whenever fifo_empty=0, and 0 when fifo_empty=1.
REQ-028 SHALL deassert fifo_empty and increment fifo_level in the cycle after a write.
REQ-029 SHALL pop on ps_rd_en=1 with fifo_empty=0; the next word appears the following cycle; ps_rd_en while empty is ignored.
REQ-030 SHALL, on a write while full with no simultaneous pop, drop the word, leave the level at DEPTH and set overflow.
REQ-031 SHALL, on a simultaneous write and pop while full, accept both with the level unchanged; on both while empty, accept the write and ignore the pop.
REQ-032 SHALL wrap the read and write pointers modulo DEPTH; the level ranges 0..DEPTH.
REQ-033 SHALL drive data_ready = (irq_thresh != 0) and (fifo_level >= irq_thresh), combinational from the level register.
REQ-034 SHALL have the health test count consecutive identical accepted raw bits before correction; the count reaches RCT_CUTOFF at the RCT_CUTOFF-th identical bit, and health_fail is set the next cycle.
REQ-035 SHALL, while health_fail=1, discard the partial word and clear the pair state; the FIFO stays readable.
REQ-036 SHALL, on clear_status=1, clear overflow, health_fail and the repetition counter next cycle; a same-cycle set event takes priority over the clear.

Reset
REQ-037 SHALL, with rst_btn_n=0 at a clock edge, reset ps_rd_data=0, fifo_empty=1, fifo_level=0, data_ready=0, overflow=0 and health_fail=0.
REQ-038 SHALL reset the pointers, bit counter, pair state and repetition counter to 0.
REQ-039 SHALL, on reset mid-word or mid-read, discard all FIFO contents and the partial word, with no write issued afterwards.

Structure
REQ-040 SHALL place the shared constants DATA_W_DEF, DEPTH_DEF, RCT_CUTOFF_DEF and a function for LW in package trng_pkg.
REQ-041 SHALL keep the FIFO in one sub-module, trng_fifo, parametrised by DATA_W and DEPTH; correction, packing and health test live in trng_ps_bridge.
REQ-042 SHALL infer the FIFO storage as RAM, with no reset on the storage array.

Verification
REQ-043 SHALL check raw mode: DATA_W=32, vn_enable=0, 32 bits alternating 1,0,... -> one word 0xAAAAAAAA, fifo_level=1 two cycles after the last bit.
REQ-044 SHALL check Von Neumann mode: pairs 10,01,00,11 repeated for 32 emitted bits -> word 0xAAAAAAAA; the 00 and 11 pairs emit nothing.
REQ-045 SHALL check overflow: DEPTH=4, write 5 words with no reads -> level=4, overflow=1, first 4 words read back in order; clear_status -> overflow=0.
REQ-046 SHALL check the health test: RCT_CUTOFF=32, 32 consecutive 1s -> health_fail=1 with no further writes; clear_status then alternating bits -> collection resumes.
REQ-047 SHALL check simultaneous write and pop at level=DEPTH -> level stays DEPTH with no overflow; irq_thresh=2 with level 1->2 -> data_ready rises in the same cycle as the level change.
REQ-048 SHALL check reset: rst_btn_n=0 after 17 bits of a word with 3 words stored -> fifo_empty=1, level 0; the next word contains only bits accepted after reset.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared constants, pair-state encoding and level-width helper for the TRNG
// post-processing bridge.
package trng_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int DEPTH_DEF      = 1024;
    localparam int RCT_CUTOFF_DEF = 32;

    typedef enum logic [1:0] {
        PAIR_NONE = 2'b00,
        PAIR_ZERO = 2'b01,
        PAIR_ONE  = 2'b10
    } pair_e;

    // Level width: must represent 0..DEPTH inclusive.
    function automatic int trng_lw(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/trng_fifo.sv
// First-word-fall-through FIFO. The head word is shown combinationally from the
// storage array; pointers wrap modulo DEPTH and the level spans 0..DEPTH.
module trng_fifo
    import trng_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  DEPTH  = DEPTH_DEF,
    localparam int LW     = trng_lw(DEPTH),
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic [LW-1:0]     level,
    output logic              drop
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              full_s, pop_s, push_s, drop_s;

    // Push/pop qualification and next pointer/level values.
    always_comb begin
        full_s = (level_q == LW'(DEPTH));
        pop_s  = rd_en && (level_q != LW'(0));
        // A full FIFO still takes a write when the head leaves in the same cycle.
        push_s = wr_en && (!full_s || pop_s);
        drop_s = wr_en && full_s && !pop_s;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array, kept free of reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign empty   = (level_q == LW'(0));
    assign level   = level_q;
    assign rd_data = empty ? DATA_W'(0) : mem_q[rd_ptr_q];
    assign drop    = drop_s;

endmodule

// File: rtl/trng_ps_bridge.sv
// TRNG post-processing bridge: repetition-count health test, optional Von
// Neumann correction, MSB-first word packing and a FWFT FIFO toward the PS.
module trng_ps_bridge
    import trng_pkg::*;
#(
    parameter int  DATA_W     = DATA_W_DEF,
    parameter int  DEPTH      = DEPTH_DEF,
    parameter int  RCT_CUTOFF = RCT_CUTOFF_DEF,
    localparam int LW         = trng_lw(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_btn_n,
    input  logic              enable,
    input  logic              vn_enable,
    input  logic              raw_bit,
    input  logic              raw_valid,
    input  logic              ps_rd_en,
    input  logic [LW-1:0]     irq_thresh,
    input  logic              clear_status,
    output logic [DATA_W-1:0] ps_rd_data,
    output logic              fifo_empty,
    output logic [LW-1:0]     fifo_level,
    output logic              data_ready,
    output logic              overflow,
    output logic              health_fail
);

    localparam int CW = $clog2(DATA_W);

    pair_e             pair_q, pair_d, pair_cur_s;
    logic              vn_prev_q, vn_prev_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              wr_q, wr_d;
    logic [7:0]        rct_cnt_q, rct_cnt_d;
    logic              rct_last_q, rct_last_d;
    logic              health_fail_q, health_fail_d;
    logic              overflow_q, overflow_d;
    logic              accept_s, emit_s, emit_bit_s, rct_trip_s;
    logic              fifo_drop_s, fifo_empty_s;
    logic [LW-1:0]     fifo_level_s;

    assign accept_s = enable && raw_valid && !health_fail_q;

    // Von Neumann pair FSM and emitted-bit selection.
    always_comb begin
        emit_s     = 1'b0;
        emit_bit_s = 1'b0;
        vn_prev_d  = vn_enable;
        pair_cur_s = (vn_enable != vn_prev_q) ? PAIR_NONE : pair_q;
        pair_d     = pair_cur_s;

        if (!enable || health_fail_q) begin
            pair_d = PAIR_NONE;
        end else if (accept_s && vn_enable) begin
            case (pair_cur_s)
                PAIR_NONE: pair_d = raw_bit ? PAIR_ONE : PAIR_ZERO;
                PAIR_ZERO: begin
                    pair_d     = PAIR_NONE;
                    emit_s     = raw_bit;
                    emit_bit_s = 1'b0;
                end
                PAIR_ONE: begin
                    pair_d     = PAIR_NONE;
                    emit_s     = !raw_bit;
                    emit_bit_s = 1'b1;
                end
                default: pair_d = PAIR_NONE;
            endcase
        end else if (accept_s) begin
            emit_s     = 1'b1;
            emit_bit_s = raw_bit;
            pair_d     = PAIR_NONE;
        end else begin
            pair_d = pair_cur_s;
        end
    end

    // Word packer; a completed word is written from shift_q on the next cycle.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        wr_d      = 1'b0;

        if (!enable || health_fail_q) begin
            bit_cnt_d = CW'(0);
            shift_d   = DATA_W'(0);
        end else if (emit_s) begin
            shift_d = {shift_q[DATA_W-2:0], emit_bit_s};
            if (bit_cnt_q == CW'(DATA_W - 1)) begin
                bit_cnt_d = CW'(0);
                wr_d      = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + CW'(1);
            end
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
    end

    // Repetition-count health test and sticky status flags.
    always_comb begin
        rct_cnt_d  = rct_cnt_q;
        rct_last_d = rct_last_q;
        // The trip is a single-cycle event so one clear_status fully re-arms.
        rct_trip_s    = (rct_cnt_q == 8'(RCT_CUTOFF)) && !health_fail_q;
        health_fail_d = rct_trip_s || (health_fail_q && !clear_status);
        overflow_d    = fifo_drop_s || (overflow_q && !clear_status);

        if (clear_status) begin
            rct_cnt_d = 8'd0;
        end else if (accept_s) begin
            rct_last_d = raw_bit;
            if ((rct_cnt_q != 8'd0) && (raw_bit == rct_last_q)) begin
                if (rct_cnt_q == 8'(RCT_CUTOFF)) begin
                    rct_cnt_d = rct_cnt_q;
                end else begin
                    rct_cnt_d = rct_cnt_q + 8'd1;
                end
            end else begin
                rct_cnt_d = 8'd1;
            end
        end else begin
            rct_cnt_d = rct_cnt_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_btn_n) begin
            pair_q        <= PAIR_NONE;
            vn_prev_q     <= 1'b0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            wr_q          <= 1'b0;
            rct_cnt_q     <= 8'd0;
            rct_last_q    <= 1'b0;
            health_fail_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            pair_q        <= pair_d;
            vn_prev_q     <= vn_prev_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            wr_q          <= wr_d;
            rct_cnt_q     <= rct_cnt_d;
            rct_last_q    <= rct_last_d;
            health_fail_q <= health_fail_d;
            overflow_q    <= overflow_d;
        end
    end

    trng_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_btn_n),
        .wr_en   (wr_q),
        .wr_data (shift_q),
        .rd_en   (ps_rd_en),
        .rd_data (ps_rd_data),
        .empty   (fifo_empty_s),
        .level   (fifo_level_s),
        .drop    (fifo_drop_s)
    );

    assign fifo_empty  = fifo_empty_s;
    assign fifo_level  = fifo_level_s;
    assign data_ready  = (irq_thresh != LW'(0)) && (fifo_level_s >= irq_thresh);
    assign overflow    = overflow_q;
    assign health_fail = health_fail_q;

endmodule

// File: tb/tb_trng_ps_bridge.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared each
// cycle against a queue-based behavioural model of the bridge.
module tb_trng_ps_bridge;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CUT   = 32;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          rst_btn_n, enable, vn_enable, raw_bit, raw_valid;
    logic          ps_rd_en, clear_status;
    logic [LW-1:0] irq_thresh;
    logic [DW-1:0] ps_rd_data;
    logic          fifo_empty, data_ready, overflow, health_fail;
    logic [LW-1:0] fifo_level;

    always #5 clk = ~clk;

    trng_ps_bridge #(.DATA_W(DW), .DEPTH(DEPTH), .RCT_CUTOFF(CUT)) dut (
        .clk          (clk),
        .rst_btn_n    (rst_btn_n),
        .enable       (enable),
        .vn_enable    (vn_enable),
        .raw_bit      (raw_bit),
        .raw_valid    (raw_valid),
        .ps_rd_en     (ps_rd_en),
        .irq_thresh   (irq_thresh),
        .clear_status (clear_status),
        .ps_rd_data   (ps_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_level   (fifo_level),
        .data_ready   (data_ready),
        .overflow     (overflow),
        .health_fail  (health_fail)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: FIFO as a queue, packer as a bit count and word.
    logic [DW-1:0] mq[$];
    int            m_bits, m_pair, m_run;
    logic [DW-1:0] m_word, m_pend_word;
    bit            m_pend, m_last, m_hf, m_ov, m_vnp;

    task automatic model_edge();
        bit pop, drop, acc, emit, ebit, new_hf, new_ov;
        int sz;
        if (!rst_btn_n) begin
            mq.delete();
            m_bits = 0; m_word = '0; m_pend = 0; m_pair = -1;
            m_run = 0; m_last = 0; m_hf = 0; m_ov = 0; m_vnp = 0;
            return;
        end
        sz   = mq.size();
        pop  = ps_rd_en && (sz > 0);
        drop = 0;
        if (pop) void'(mq.pop_front());
        if (m_pend) begin
            if (sz == DEPTH && !pop) drop = 1;
            else mq.push_back(m_pend_word);
        end
        acc    = enable && raw_valid && !m_hf;
        new_hf = (m_run == CUT && !m_hf) || (m_hf && !clear_status);
        new_ov = drop || (m_ov && !clear_status);
        if (clear_status) m_run = 0;
        else if (acc) begin
            m_run  = (m_run > 0 && raw_bit == m_last) ? ((m_run < CUT) ? m_run + 1 : CUT) : 1;
            m_last = raw_bit;
        end
        m_pend = 0; emit = 0; ebit = 0;
        if (!enable || m_hf) begin
            m_bits = 0; m_word = '0; m_pair = -1;
        end else begin
            if (vn_enable != m_vnp) m_pair = -1;
            if (acc) begin
                if (!vn_enable) begin
                    emit = 1; ebit = raw_bit;
                end else if (m_pair < 0) begin
                    m_pair = raw_bit ? 1 : 0;
                end else begin
                    if (m_pair != int'(raw_bit)) begin
                        emit = 1; ebit = (m_pair == 1);
                    end
                    m_pair = -1;
                end
            end
            if (emit) begin
                m_word = {m_word[DW-2:0], ebit};
                m_bits++;
                if (m_bits == DW) begin
                    m_pend = 1; m_pend_word = m_word; m_bits = 0;
                end
            end
        end
        m_vnp = vn_enable;
        m_hf  = new_hf;
        m_ov  = new_ov;
    endtask

    task automatic compare_all();
        int sz;
        sz = mq.size();
        check("level", fifo_level, sz);
        check("empty", fifo_empty, sz == 0);
        check("rd_data", ps_rd_data, (sz > 0) ? mq[0] : '0);
        check("data_ready", data_ready, (irq_thresh != 0) && (sz >= int'(irq_thresh)));
        check("overflow", overflow, m_ov);
        check("health_fail", health_fail, m_hf);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic feed_word(input logic [DW-1:0] w);
        raw_valid = 1'b1;
        for (int i = DW - 1; i >= 0; i--) begin
            raw_bit = w[i];
            cycle();
        end
        raw_valid = 1'b0;
    endtask

    task automatic drain();
        raw_valid = 1'b0;
        ps_rd_en  = 1'b1;
        idle(DEPTH + 2);
        ps_rd_en  = 1'b0;
    endtask

    logic [DW-1:0] words[5];
    logic [7:0]    pat;
    bit            bias;
    bit            slow_rd;

    initial begin
        rst_btn_n = 1'b0; enable = 1'b0; vn_enable = 1'b0; raw_bit = 1'b0;
        raw_valid = 1'b0; ps_rd_en = 1'b0; clear_status = 1'b0; irq_thresh = '0;
        idle(2);
        check("rst_level", fifo_level, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_data", ps_rd_data, 0);
        check("rst_ready", data_ready, 0);
        check("rst_ovf", overflow, 0);
        check("rst_hf", health_fail, 0);
        rst_btn_n = 1'b1;
        enable    = 1'b1;
        cycle();

        // Raw mode, alternating bits starting with 1.
        raw_valid = 1'b1;
        for (int i = 0; i < DW; i++) begin
            raw_bit = (i % 2 == 0);
            cycle();
        end
        raw_valid = 1'b0;
        check("raw_level_before", fifo_level, 0);
        cycle();
        check("raw_level", fifo_level, 1);
        check("raw_word", ps_rd_data, 32'hAAAAAAAA);
        ps_rd_en = 1'b1; cycle(); ps_rd_en = 1'b0;
        check("raw_popped", fifo_empty, 1);

        // Von Neumann: pairs 10,01,00,11 each emit 1,0.
        vn_enable = 1'b1;
        cycle();
        pat = 8'b10010011;
        raw_valid = 1'b1;
        for (int g = 0; g < 16; g++) begin
            for (int j = 7; j >= 0; j--) begin
                raw_bit = pat[j];
                cycle();
            end
        end
        raw_valid = 1'b0;
        cycle();
        check("vn_level", fifo_level, 1);
        check("vn_word", ps_rd_data, 32'hAAAAAAAA);
        drain();
        vn_enable = 1'b0;
        cycle();

        // Overflow: five words into a four-deep FIFO.
        for (int k = 0; k < 5; k++) words[k] = $urandom;
        for (int k = 0; k < 5; k++) feed_word(words[k]);
        idle(2);
        check("ovf_level", fifo_level, DEPTH);
        check("ovf_flag", overflow, 1);
        for (int k = 0; k < DEPTH; k++) begin
            check("ovf_order", ps_rd_data, words[k]);
            ps_rd_en = 1'b1; cycle(); ps_rd_en = 1'b0;
        end
        check("ovf_drained", fifo_empty, 1);
        clear_status = 1'b1; cycle(); clear_status = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Write and pop together while full.
        for (int k = 0; k < 5; k++) words[k] = $urandom;
        for (int k = 0; k < 5; k++) feed_word(words[k]);
        ps_rd_en = 1'b1; cycle(); ps_rd_en = 1'b0;
        check("full_wp_level", fifo_level, DEPTH);
        check("full_wp_ovf", overflow, 0);
        check("full_wp_head", ps_rd_data, words[1]);

        // data_ready tracks the level in the same cycle.
        drain();
        irq_thresh = 3'd2;
        feed_word($urandom);
        cycle();
        check("thr_lvl1_ready", data_ready, 0);
        feed_word($urandom);
        check("thr_pending_ready", data_ready, 0);
        cycle();
        check("thr_lvl2", fifo_level, 2);
        check("thr_lvl2_ready", data_ready, 1);
        irq_thresh = '0;
        drain();

        // Health test: 0,1,0 then a long run of ones.
        raw_valid = 1'b1;
        raw_bit = 1'b0; cycle();
        raw_bit = 1'b1; cycle();
        raw_bit = 1'b0; cycle();
        raw_bit = 1'b1;
        idle(CUT);
        check("hf_not_yet", health_fail, 0);
        cycle();
        check("hf_set", health_fail, 1);
        check("hf_word", ps_rd_data, 32'h5FFFFFFF);
        idle(40);
        check("hf_no_write", fifo_level, 1);
        raw_valid = 1'b0;
        clear_status = 1'b1; cycle(); clear_status = 1'b0;
        check("hf_cleared", health_fail, 0);
        feed_word(32'hAAAAAAAA);
        cycle();
        check("hf_resumed", fifo_level, 2);
        drain();

        // Reset mid-word with three words stored.
        for (int k = 0; k < 3; k++) feed_word($urandom);
        cycle();
        check("rstw_level3", fifo_level, 3);
        raw_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            raw_bit = $urandom_range(0, 1);
            cycle();
        end
        rst_btn_n = 1'b0; raw_valid = 1'b0;
        cycle();
        rst_btn_n = 1'b1;
        check("rstw_empty", fifo_empty, 1);
        check("rstw_level", fifo_level, 0);
        idle(3);
        check("rstw_no_write", fifo_level, 0);
        words[0] = $urandom;
        feed_word(words[0]);
        cycle();
        check("rstw_next_level", fifo_level, 1);
        check("rstw_next_word", ps_rd_data, words[0]);

        // Randomized traffic against the model.
        bias = 0; slow_rd = 0;
        for (int n = 0; n < 6000; n++) begin
            if (n % 250 == 0) begin
                bias    = ($urandom_range(0, 3) == 0);
                slow_rd = ($urandom_range(0, 1) == 0);
            end
            rst_btn_n    = ($urandom_range(0, 799) != 0);
            enable       = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 59) == 0) vn_enable = ~vn_enable;
            raw_valid    = ($urandom_range(0, 2) != 0);
            raw_bit      = bias ? ($urandom_range(0, 15) != 0) : 1'($urandom_range(0, 1));
            ps_rd_en     = slow_rd ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 7) == 0);
            clear_status = ($urandom_range(0, 99) == 0);
            irq_thresh   = 3'($urandom_range(0, 5));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
